// File: rtl/mem_port_arbiter_pkg.sv
// Shared defaults and helpers for the data-memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_ADDR_W   = 22;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_READ_LAT = 1;

  // Width of a requester index; never narrower than one bit.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr.sv
// Round-robin arbiter: rotating-priority search starting at rr_ptr.
module rr_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_vld
);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               j;

  // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      cand = IDX_W'(j);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
  end

  // No grant while in reset so nothing is accepted in the reset cycle.
  always_comb begin
    grant_vld = found & ~rst;
    grant_idx = sel;
    grant     = grant_vld ? (NUM_REQ'(1) << sel) : '0;
  end

  // Pointer moves just past the winner; holds when nobody is granted.
  always_ff @(posedge clk) begin
    if (rst)
      rr_ptr <= '0;
    else if (grant_vld)
      rr_ptr <= (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + IDX_W'(1);
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port data memory among NUM_REQ requesters; routes read
// data back to the issuing requester via a tag pipeline.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter  int NUM_REQ  = DEF_NUM_REQ,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int READ_LAT = DEF_READ_LAT,
  localparam int IDX_W    = req_idx_w(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  logic [NUM_REQ-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_W-1:0] wdata_a;
  logic [IDX_W-1:0]               gidx;
  logic                           accept;
  logic                           rd_acc;

  // Tag pipeline: stage 0 captured at acceptance, stage READ_LAT lines up
  // with mem_rdata being valid.
  logic [READ_LAT:0]              vld_pipe;
  logic [READ_LAT:0][IDX_W-1:0]   tag_pipe;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;
  assign rd_acc  = accept & ~req_we[gidx];

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .grant     (req_ready),
    .grant_idx (gidx),
    .grant_vld (accept)
  );

  // Issue register: the accepted request drives the memory one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_en <= accept;
      mem_we <= accept & req_we[gidx];
      if (accept) begin
        mem_addr  <= addr_a[gidx];
        mem_wdata <= wdata_a[gidx];
      end
    end
  end

  // Shift read tags along with the memory access; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      tag_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[READ_LAT-1:0], rd_acc};
      tag_pipe <= {tag_pipe[READ_LAT-1:0], gidx};
    end
  end

  // Register returning read data and pulse the owning requester's valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= vld_pipe[READ_LAT] ? (NUM_REQ'(1) << tag_pipe[READ_LAT]) : '0;
      if (vld_pipe[READ_LAT])
        rsp_rdata <= mem_rdata;
    end
  end

endmodule
